// File: rtl/iir_chan_sched.sv
// iir_chan_sched: round-robin scheduler sharing one IIR engine among NCH sample sources
// Optional feature macro: IIR_SCHED_TIMEOUT_EN (engine watchdog, adds TIMEOUT parameter and err_timeout port)
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   ch_din/valid    per-channel samples (channel i at [i*DW +: DW]) and valids
//   ch_ready        per-channel holding buffer free
//   eng_din/ch      sample and channel tag to engine, stable from ISSUE through OUT
//   eng_din_valid   one-cycle engine start pulse
//   eng_dout/valid  engine result and its one-cycle strobe
//   dout/dout_ch    filtered sample and its channel, held until the next result
//   dout_valid      one-cycle result strobe
//   err_spurious    sticky: engine strobe while no sample was awaited
//   err_timeout     sticky: engine failed to answer within TIMEOUT cycles (macro only)
module iir_chan_sched #(
  parameter int NCH = 4,
  parameter int DW = 18,
  parameter int CW = 2
`ifdef IIR_SCHED_TIMEOUT_EN
  , parameter int TIMEOUT = 64
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic [NCH*DW-1:0] ch_din,
  input  logic [NCH-1:0] ch_valid,
  output logic [NCH-1:0] ch_ready,
  output logic [DW-1:0] eng_din,
  output logic [CW-1:0] eng_ch,
  output logic eng_din_valid,
  input  logic [DW-1:0] eng_dout,
  input  logic eng_dout_valid,
  output logic [DW-1:0] dout,
  output logic [CW-1:0] dout_ch,
  output logic dout_valid,
  output logic err_spurious
`ifdef IIR_SCHED_TIMEOUT_EN
  , output logic err_timeout
`endif
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} state_t;
  state_t state, nxt;
  logic [NCH-1:0] pend;
  logic [DW-1:0] bufs [NCH];
  logic [CW-1:0] rr_ptr, grant, nrr;
  logic any, issued, to_hit, done;
  assign any = |pend;
  assign ch_ready = ~pend;
  assign eng_din_valid = state == ISSUE;
  assign dout_valid = state == OUT;
  assign done = eng_dout_valid || to_hit;
  // highest offset first so the channel closest to rr_ptr is written last and wins
  always_comb begin
    grant = '0;
    for (int j = NCH-1; j >= 0; j--) begin
      if (pend[(int'(rr_ptr) + j) % NCH]) grant = CW'((int'(rr_ptr) + j) % NCH);
    end
  end
  assign nrr = (int'(grant) == NCH-1) ? '0 : grant + CW'(1);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend <= '0;
      for (int j = 0; j < NCH; j++) bufs[j] <= '0;
    end else begin
      for (int j = 0; j < NCH; j++) begin
        if (ch_valid[j] && ch_ready[j]) begin
          bufs[j] <= ch_din[j*DW +: DW];
          pend[j] <= 1'b1;
        end else if (state == ISSUE && int'(eng_ch) == j) begin
          pend[j] <= 1'b0;
        end
      end
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else state <= nxt;
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE:  nxt = any ? ISSUE : IDLE;
      ISSUE: nxt = WAIT;
      WAIT:  nxt = done ? OUT : WAIT;
      OUT:   nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  // issued distinguishes a stale strobe from an abandoned pre-reset sample from a real protocol error
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr <= '0;
      eng_ch <= '0;
      eng_din <= '0;
      dout <= '0;
      dout_ch <= '0;
      err_spurious <= 1'b0;
      issued <= 1'b0;
    end else begin
      if (state == IDLE && any) begin
        eng_ch <= grant;
        eng_din <= bufs[grant];
        rr_ptr <= nrr;
        issued <= 1'b1;
      end
      if (state == WAIT && done) begin
        dout <= eng_dout_valid ? eng_dout : '0;
        dout_ch <= eng_ch;
      end
      if (eng_dout_valid && (state == ISSUE || state == OUT || (state == IDLE && issued))) err_spurious <= 1'b1;
    end
  end
`ifdef IIR_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT);
  logic [TW-1:0] cnt;
  assign to_hit = state == WAIT && !eng_dout_valid && cnt == TW'(TIMEOUT-1);
  // counter is zero outside WAIT, so it restarts on every WAIT entry
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      err_timeout <= 1'b0;
    end else begin
      cnt <= (state == WAIT) ? cnt + TW'(1) : '0;
      if (to_hit) err_timeout <= 1'b1;
    end
  end
`else
  assign to_hit = 1'b0;
`endif
endmodule

// File: tb/tb_iir_chan_sched.sv
// tb_iir_chan_sched: self-checking bench for iir_chan_sched with a timeline model and directed tests
module tb_iir_chan_sched;
  localparam int NCH = 4;
  localparam int DW = 18;
  localparam int CW = 2;
  localparam int TO = 16;
  logic clk = 1'b0;
  logic rst;
  logic [NCH*DW-1:0] ch_din;
  logic [NCH-1:0] ch_valid, ch_ready;
  logic [DW-1:0] eng_din, eng_dout, dout, eng_val, frc_val;
  logic [CW-1:0] eng_ch, dout_ch;
  logic eng_din_valid, eng_dout_valid, dout_valid, err_spurious;
  logic eng_strb, frc_strb, eng_mute;
  int eng_lat, ecnt;
`ifdef IIR_SCHED_TIMEOUT_EN
  logic err_timeout;
`endif
  always #5 clk = ~clk;
  assign eng_dout_valid = eng_strb | frc_strb;
  assign eng_dout = frc_strb ? frc_val : eng_val;
  iir_chan_sched #(
    .NCH(NCH), .DW(DW), .CW(CW)
`ifdef IIR_SCHED_TIMEOUT_EN
    , .TIMEOUT(TO)
`endif
  ) dut (
    .clk(clk), .rst(rst), .ch_din(ch_din), .ch_valid(ch_valid), .ch_ready(ch_ready),
    .eng_din(eng_din), .eng_ch(eng_ch), .eng_din_valid(eng_din_valid),
    .eng_dout(eng_dout), .eng_dout_valid(eng_dout_valid),
    .dout(dout), .dout_ch(dout_ch), .dout_valid(dout_valid), .err_spurious(err_spurious)
`ifdef IIR_SCHED_TIMEOUT_EN
    , .err_timeout(err_timeout)
`endif
  );
  int checks = 0;
  int failures = 0;
  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask
  // engine stand-in: answers eng_din+1 eng_lat cycles after the start pulse unless muted
  initial begin
    eng_strb = 1'b0;
    eng_val = '0;
    ecnt = 0;
    forever begin
      @(negedge clk);
      eng_strb = 1'b0;
      if (ecnt > 0) begin
        ecnt--;
        if (ecnt == 0) eng_strb = 1'b1;
      end
      if (eng_din_valid && !eng_mute) begin
        ecnt = eng_lat;
        eng_val = eng_din + DW'(1);
      end
    end
  end
  // timeline model: which channels hold a sample, who is granted, what is awaited
  bit busy [NCH];
  logic [DW-1:0] held [NCH];
  int rr, tag, tcnt;
  logic [DW-1:0] tdin, xdout;
  logic [CW-1:0] xch;
  bit awaiting, xpulse, xout, xspur, xto, issued, idle, npulse, nout, found;
  logic [NCH-1:0] rdy;
  int grant_log[$];
  task automatic mreset();
    for (int i = 0; i < NCH; i++) begin busy[i] = 0; held[i] = '0; end
    rr = 0; tag = 0; tcnt = 0; tdin = '0; xdout = '0; xch = '0;
    awaiting = 0; xpulse = 0; xout = 0; xspur = 0; xto = 0; issued = 0;
  endtask
  initial begin
    mreset();
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        mreset();
        chk("rst_ch_ready", ch_ready, {NCH{1'b1}});
        chk("rst_eng_din_valid", eng_din_valid, 0);
        chk("rst_dout_valid", dout_valid, 0);
        chk("rst_dout", dout, 0);
        chk("rst_dout_ch", dout_ch, 0);
        chk("rst_eng_ch", eng_ch, 0);
        chk("rst_eng_din", eng_din, 0);
        chk("rst_err_spurious", err_spurious, 0);
        continue;
      end
      for (int i = 0; i < NCH; i++) rdy[i] = !busy[i];
      chk("ch_ready", ch_ready, rdy);
      chk("eng_din_valid", eng_din_valid, xpulse);
      chk("dout_valid", dout_valid, xout);
      chk("dout", dout, xdout);
      chk("dout_ch", dout_ch, xch);
      chk("err_spurious", err_spurious, xspur);
`ifdef IIR_SCHED_TIMEOUT_EN
      chk("err_timeout", err_timeout, xto);
`endif
      if (xpulse || awaiting || xout) begin
        chk("eng_ch", eng_ch, tag);
        chk("eng_din", eng_din, tdin);
      end
      if (eng_din_valid) grant_log.push_back(int'(eng_ch));
      idle = !xpulse && !awaiting && !xout;
      nout = 0;
      if (awaiting) begin
        if (eng_dout_valid) begin
          nout = 1; xdout = eng_dout; xch = CW'(tag);
        end
`ifdef IIR_SCHED_TIMEOUT_EN
        else if (tcnt == TO-1) begin
          nout = 1; xdout = '0; xch = CW'(tag); xto = 1;
        end
`endif
        tcnt++;
      end else if (eng_dout_valid && issued) xspur = 1;
      awaiting = (awaiting && !nout) || xpulse;
      if (xpulse) begin busy[tag] = 0; tcnt = 0; end
      npulse = 0;
      if (idle) begin
        found = 0;
        for (int k = 0; k < NCH; k++) begin
          if (!found && busy[(rr + k) % NCH]) begin
            found = 1; tag = (rr + k) % NCH;
          end
        end
        if (found) begin
          npulse = 1; issued = 1; tdin = held[tag]; rr = (tag + 1) % NCH;
        end
      end
      for (int i = 0; i < NCH; i++) begin
        if (ch_valid[i] && rdy[i]) begin busy[i] = 1; held[i] = ch_din[i*DW +: DW]; end
      end
      xpulse = npulse;
      xout = nout;
    end
  end
  task automatic tick();
    @(negedge clk);
    #1;
  endtask
  task automatic wait_sig(input bit dv, input int lim, output int n);
    n = 0;
    while (!(dv ? dout_valid : eng_din_valid) && n < lim) begin tick(); n++; end
    if (!(dv ? dout_valid : eng_din_valid)) chk(dv ? "wait_dout_valid" : "wait_eng_din_valid", 0, 1);
  endtask
  task automatic do_reset();
    tick();
    rst = 1'b0; ch_valid = '0;
    repeat (2) tick();
    rst = 1'b1;
  endtask
  int n, m;
  bit seen_out, seen_strb;
  initial begin
    rst = 1'b0; ch_valid = '0; ch_din = '0;
    frc_strb = 1'b0; frc_val = '0; eng_mute = 1'b0; eng_lat = 9;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    // single channel: ch2 sends 0x00123
    ch_din[2*DW +: DW] = 18'h00123; ch_valid = 4'b0100;
    tick();
    ch_valid = '0;
    chk("t1_ready2_after_capture", ch_ready[2], 0);
    wait_sig(0, 20, n);
    chk("t1_issue_latency", n, 1);
    chk("t1_eng_ch", eng_ch, 2);
    chk("t1_eng_din", eng_din, 18'h00123);
    chk("t1_ready2_in_issue", ch_ready[2], 0);
    tick();
    chk("t1_ready2_after_issue", ch_ready[2], 1);
    chk("t1_single_pulse", eng_din_valid, 0);
    wait_sig(1, 40, m);
    chk("t1_out_latency", m + 1, 10);
    chk("t1_dout", dout, 18'h00124);
    chk("t1_dout_ch", dout_ch, 2);
    tick();
    chk("t1_dout_valid_one_cycle", dout_valid, 0);
    // stray engine strobe while idle after a real issue
    frc_val = 18'h3ffff; frc_strb = 1'b1;
    tick();
    frc_strb = 1'b0;
    chk("t5_err_spurious_set", err_spurious, 1);
    chk("t5_dout_unchanged", dout, 18'h00124);
    chk("t5_no_dout_valid", dout_valid, 0);
    repeat (5) tick();
    chk("t5_err_spurious_sticky", err_spurious, 1);
    // all four channels at once
    do_reset();
    grant_log.delete();
    tick();
    for (int i = 0; i < NCH; i++) ch_din[i*DW +: DW] = DW'(i + 1);
    ch_valid = 4'b1111;
    tick();
    ch_valid = '0;
    for (int i = 0; i < NCH; i++) begin
      wait_sig(1, 40, n);
      chk("t2_dout", dout, i + 2);
      chk("t2_dout_ch", dout_ch, i);
      tick();
    end
    chk("t2_grants", grant_log.size(), 4);
    for (int i = 0; i < grant_log.size() && i < 4; i++) chk("t2_grant_order", grant_log[i], i);
    // fairness: ch0 re-sends whenever ready, ch3 holds one sample
    do_reset();
    grant_log.delete();
    tick();
    ch_din[0 +: DW] = 18'h00010; ch_din[3*DW +: DW] = 18'h00033; ch_valid = 4'b1001;
    tick();
    ch_valid = 4'b0001;
    wait_sig(1, 40, n);
    chk("t3_first_ch", dout_ch, 0);
    tick();
    wait_sig(1, 40, n);
    chk("t3_second_ch", dout_ch, 3);
    chk("t3_second_dout", dout, 18'h00034);
    chk("t3_grant1", grant_log.size() > 1 ? grant_log[1] : -1, 3);
    ch_valid = '0;
    // reset while waiting, engine answers 3 cycles after reset asserted
    do_reset();
    eng_lat = 5;
    tick();
    ch_din[1*DW +: DW] = 18'h00077; ch_valid = 4'b0010;
    tick();
    ch_valid = '0;
    wait_sig(0, 20, n);
    repeat (2) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    seen_out = 0; seen_strb = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (dout_valid) seen_out = 1;
      if (eng_dout_valid) seen_strb = 1;
    end
    chk("t4_late_strobe_happened", seen_strb, 1);
    chk("t4_no_dout_valid", seen_out, 0);
    chk("t4_ready_all", ch_ready, 4'b1111);
    chk("t4_err_spurious", err_spurious, 0);
    eng_lat = 9;
`ifdef IIR_SCHED_TIMEOUT_EN
    // silent engine: watchdog fires, next channel is still served
    do_reset();
    eng_mute = 1'b1;
    tick();
    ch_din[1*DW +: DW] = 18'h00055; ch_din[2*DW +: DW] = 18'h00066; ch_valid = 4'b0110;
    tick();
    ch_valid = '0;
    wait_sig(0, 20, n);
    chk("t6_first_ch", eng_ch, 1);
    tick();
    wait_sig(1, 60, m);
    chk("t6_timeout_latency", m + 1, TO + 1);
    chk("t6_dout_zero", dout, 0);
    chk("t6_dout_ch", dout_ch, 1);
    eng_mute = 1'b0;
    tick();
    chk("t6_err_timeout", err_timeout, 1);
    wait_sig(0, 20, n);
    chk("t6_next_ch", eng_ch, 2);
    tick();
    wait_sig(1, 40, n);
    chk("t6_next_dout", dout, 18'h00067);
    chk("t6_err_spurious", err_spurious, 0);
`endif
    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
